// File: rtl/gf163_digit_feeder_if.sv
// Operand/digit bundle between an operand source and gf163_digit_feeder.
// The slave modport is the feeder side; master is the source/array side.
interface gf163_digit_feeder_if #(
  parameter int unsigned M = 163,
  parameter int unsigned D = 16
);
  logic         op_valid;
  logic         op_ready;
  logic [M-1:0] a_op;
  logic [M-1:0] b_op;
  logic [M-1:0] g_op;
  logic [D-1:0] a_in;
  logic [D-1:0] b_in;
  logic [D-1:0] g_in;
  logic         ctr;
  logic         last;
  logic         busy;

  modport slave (
    input  op_valid, a_op, b_op, g_op,
    output op_ready, a_in, b_in, g_in, ctr, last, busy
  );

  modport master (
    output op_valid, a_op, b_op, g_op,
    input  op_ready, a_in, b_in, g_in, ctr, last, busy
  );
endinterface

// File: rtl/gf163_digit_feeder.sv
// Serializes A, B and G into D-bit digits for the GF(2^163) systolic multiplier.
// Digits go MSB first; define FEEDER_LSB_FIRST_EN for LSB-first order.
module gf163_digit_feeder #(
  parameter int unsigned M  = 163,
  parameter int unsigned D  = 16,
  parameter int unsigned ND = 11
) (
  input logic                 clk,
  input logic                 rstn,
  gf163_digit_feeder_if.slave bus
);
  localparam int unsigned W  = ND * D;
  localparam int unsigned KW = $clog2(ND);
  localparam logic [KW-1:0] LAST_K = KW'(ND - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d, g_sh_q, g_sh_d;
  logic [D-1:0]  a_in_q, a_in_d, b_in_q, b_in_d, g_in_q, g_in_d;
  logic          ctr_q, ctr_d, last_q, last_d, busy_q, busy_d;
  logic          op_ready, accept;
  logic [W-1:0]  a_pad, b_pad, g_pad;

  function automatic logic [D-1:0] head(input logic [W-1:0] v);
`ifdef FEEDER_LSB_FIRST_EN
    return v[D-1:0];
`else
    return v[W-1 -: D];
`endif
  endfunction

  function automatic logic [W-1:0] tail(input logic [W-1:0] v);
`ifdef FEEDER_LSB_FIRST_EN
    return v >> D;
`else
    return v << D;
`endif
  endfunction

  assign a_pad = {{(W-M){1'b0}}, bus.a_op};
  assign b_pad = {{(W-M){1'b0}}, bus.b_op};
  assign g_pad = {{(W-M){1'b0}}, bus.g_op};

  // Ready in the last-digit cycle lets a new set follow with no gap.
  assign op_ready = rstn && ((state_q == IDLE) || (k_q == LAST_K));
  assign accept   = bus.op_valid && op_ready;

  // Shift registers hold the digits still to come; the digit on the bus
  // is loaded into the output registers one edge ahead.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    g_sh_d  = g_sh_q;
    a_in_d  = '0;
    b_in_d  = '0;
    g_in_d  = '0;
    if (accept) begin
      state_d = SHIFT;
      k_d     = '0;
      a_in_d  = head(a_pad);
      b_in_d  = head(b_pad);
      g_in_d  = head(g_pad);
      a_sh_d  = tail(a_pad);
      b_sh_d  = tail(b_pad);
      g_sh_d  = tail(g_pad);
    end else if (state_q == SHIFT && k_q != LAST_K) begin
      k_d    = k_q + KW'(1);
      a_in_d = head(a_sh_q);
      b_in_d = head(b_sh_q);
      g_in_d = head(g_sh_q);
      a_sh_d = tail(a_sh_q);
      b_sh_d = tail(b_sh_q);
      g_sh_d = tail(g_sh_q);
    end else begin
      state_d = IDLE;
      k_d     = '0;
    end
    busy_d = (state_d == SHIFT);
    ctr_d  = busy_d && (k_d == '0);
    last_d = busy_d && (k_d == LAST_K);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      g_sh_q  <= '0;
      a_in_q  <= '0;
      b_in_q  <= '0;
      g_in_q  <= '0;
      ctr_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      g_sh_q  <= g_sh_d;
      a_in_q  <= a_in_d;
      b_in_q  <= b_in_d;
      g_in_q  <= g_in_d;
      ctr_q   <= ctr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.op_ready = op_ready;
  assign bus.a_in     = a_in_q;
  assign bus.b_in     = b_in_q;
  assign bus.g_in     = g_in_q;
  assign bus.ctr      = ctr_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;
endmodule
